// File: rtl/cc_apb_master.sv
// APB initiator for the cache-controller configuration path.
// Takes one register request over valid/ready, runs a single SETUP/ACCESS
// transfer, and returns read data and error status on a valid/ready response
// channel. A wait-state watchdog aborts transfers to a slave that never answers.
module cc_apb_master #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic              pready_i,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pslverr_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    // A zero-width counter is illegal, so the disabled watchdog keeps one bit.
    localparam int CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    // Count value during the last allowed ACCESS cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_accept;
    logic              w_done;
    logic              w_tmo;

    // State register; reset drops psel/penable immediately since they decode from state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived handshake/APB control outputs.
    always_comb begin
        w_next      = r_state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_accept = 1'b1;
                    w_next   = S_SETUP;
                end
            end
            S_SETUP: begin
                psel_o = 1'b1;
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                // pready wins over a timeout landing on the same cycle.
                if (pready_i) begin
                    w_done = 1'b1;
                    w_next = S_RESP;
                end else if ((TIMEOUT_CYC != 0) && (r_wait_cnt == CNT_LAST)) begin
                    w_tmo  = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ACCESS wait-state counter; held at zero in every other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ACCESS) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Request latch; APB address/direction/data hold between transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_paddr  <= req_addr_i;
            r_pwrite <= req_write_i;
            r_pwdata <= req_wdata_i;
        end
    end

    // Response capture on completion or watchdog abort; held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_done) begin
            r_rdata <= (r_pwrite || pslverr_i) ? '0 : prdata_i;
            r_err   <= pslverr_i;
        end else if (w_tmo) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end
    end

    assign paddr_o     = r_paddr;
    assign pwrite_o    = r_pwrite;
    assign pwdata_o    = r_pwdata;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_cc_apb_master.sv
// Directed bench for cc_apb_master: write, read, wait states, slave error,
// watchdog timeout, response back-pressure and reset during ACCESS.
module tb_cc_apb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [11:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        psel_o;
    logic        penable_o;
    logic [11:0] paddr_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    int n_total = 0;
    int n_bad   = 0;

    cc_apb_master #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_write_i(req_write_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .psel_o     (psel_o),
        .penable_o  (penable_o),
        .paddr_o    (paddr_o),
        .pwrite_o   (pwrite_o),
        .pwdata_o   (pwdata_o),
        .pready_i   (pready_i),
        .prdata_i   (prdata_i),
        .pslverr_i  (pslverr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer. Cycle of the accept handshake = cycle 0; SETUP = 1;
    // ACCESS from 2; RESP follows. pready is raised in ACCESS cycle index
    // 'waits' (0-based). 'hold' = response cycles with rsp_ready low.
    task automatic xfer(input string tag, input bit wr, input logic [11:0] a,
                        input logic [31:0] wd, input int waits, input logic [31:0] sd,
                        input bit serr, input int hold, input int exp_acc,
                        input logic [31:0] exp_rd, input bit exp_err);
        int acc;
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = a;
        req_wdata_i = wd;
        pready_i    = 1'b0;
        rsp_ready_i = 1'b0;
        chk({tag, ".ready_idle"}, 32'(req_ready_o), 32'd1);
        chk({tag, ".psel_idle"}, 32'(psel_o), 32'd0);
        tick();
        req_valid_i = 1'b0;
        req_addr_i  = 12'hFFF;
        req_wdata_i = 32'h0;
        chk({tag, ".setup_psel"}, 32'(psel_o), 32'd1);
        chk({tag, ".setup_pen"}, 32'(penable_o), 32'd0);
        chk({tag, ".setup_addr"}, 32'(paddr_o), 32'(a));
        chk({tag, ".setup_wr"}, 32'(pwrite_o), 32'(wr));
        chk({tag, ".ready_busy"}, 32'(req_ready_o), 32'd0);
        if (wr) chk({tag, ".pwdata"}, pwdata_o, wd);
        tick();
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(psel_o && penable_o)) break;
            acc++;
            chk({tag, ".acc_addr"}, 32'(paddr_o), 32'(a));
            pready_i  = (i == waits);
            prdata_i  = sd;
            pslverr_i = serr;
            tick();
            pready_i  = 1'b0;
            pslverr_i = 1'b0;
            prdata_i  = 32'hBAD0BAD0;
        end
        chk({tag, ".acc_cycles"}, 32'(acc), 32'(exp_acc));
        chk({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, ".rsp_psel"}, 32'(psel_o), 32'd0);
        chk({tag, ".rsp_pen"}, 32'(penable_o), 32'd0);
        chk({tag, ".rdata"}, rsp_rdata_o, exp_rd);
        chk({tag, ".err"}, 32'(rsp_err_o), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, ".hold_valid"}, 32'(rsp_valid_o), 32'd1);
            chk({tag, ".hold_rdata"}, rsp_rdata_o, exp_rd);
            chk({tag, ".hold_err"}, 32'(rsp_err_o), 32'(exp_err));
            chk({tag, ".hold_ready"}, 32'(req_ready_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk({tag, ".done_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, ".done_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, ".kept_rdata"}, rsp_rdata_o, exp_rd);
        chk({tag, ".kept_addr"}, 32'(paddr_o), 32'(a));
    endtask

    initial begin
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b0;
        pready_i    = 1'b0;
        prdata_i    = '0;
        pslverr_i   = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        chk("rst.req_ready", 32'(req_ready_o), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst.psel", 32'(psel_o), 32'd0);
        chk("rst.penable", 32'(penable_o), 32'd0);
        chk("rst.paddr", 32'(paddr_o), 32'd0);
        chk("rst.pwdata", pwdata_o, 32'd0);
        chk("rst.rdata", rsp_rdata_o, 32'd0);
        chk("rst.err", 32'(rsp_err_o), 32'd0);

        // tag, wr, addr, wdata, waits, slave data, slverr, hold, acc, rdata, err
        xfer("wr0",   1'b1, 12'h000, 32'hDEADBEEF, 0,   32'h12345678, 1'b0, 0, 1,  32'h0,        1'b0);
        xfer("rd0",   1'b0, 12'h000, 32'h0,        0,   32'h00010101, 1'b0, 0, 1,  32'h00010101, 1'b0);
        xfer("rdws3", 1'b0, 12'h124, 32'h0,        3,   32'hCAFE0003, 1'b0, 0, 4,  32'hCAFE0003, 1'b0);
        xfer("rderr", 1'b0, 12'h040, 32'h0,        0,   32'h55AA55AA, 1'b1, 0, 1,  32'h0,        1'b1);
        xfer("tmo",   1'b0, 12'h080, 32'h0,        100, 32'h77777777, 1'b0, 0, 16, 32'h0,        1'b1);
        xfer("edge",  1'b0, 12'h084, 32'h0,        15,  32'hA5A5000F, 1'b0, 0, 16, 32'hA5A5000F, 1'b0);
        xfer("after", 1'b0, 12'h088, 32'h0,        1,   32'h0BADF00D, 1'b0, 0, 2,  32'h0BADF00D, 1'b0);
        xfer("hold5", 1'b1, 12'h3FC, 32'h13572468, 2,   32'hFFFFFFFF, 1'b0, 5, 3,  32'h0,        1'b0);

        // Reset during ACCESS: psel/penable drop before the next edge, no response.
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 12'h200;
        tick();
        req_valid_i = 1'b0;
        tick();
        chk("mid.access_pen", 32'(penable_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid.psel_async", 32'(psel_o), 32'd0);
        chk("mid.pen_async", 32'(penable_o), 32'd0);
        chk("mid.ready_async", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        pready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid.no_rsp", 32'(rsp_valid_o), 32'd0);
            chk("mid.no_psel", 32'(psel_o), 32'd0);
        end
        pready_i = 1'b0;
        chk("mid.paddr_cleared", 32'(paddr_o), 32'd0);

        xfer("post",  1'b0, 12'h010, 32'h0,        0,   32'h89ABCDEF, 1'b0, 0, 1,  32'h89ABCDEF, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Watchdog for the bench itself.
    initial begin
        #200000;
        $display("FAIL bench_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
